// File: rtl/blowfish128_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : blowfish128_round_ctrl_if
// Description : Bundle of every non-clock signal of blowfish128_round_ctrl.
//               Carries the host request/result bus, the subkey (P-array)
//               lookup bus and the F-function handshake.
//   slave  modport : controller view (drives PAddr, FEn, FX, Busy, Done,
//                    Error, DataOut; receives the rest)
//   master modport : environment view (host, P-array, F-function)
// Revision    : 1.0 - initial release
// ============================================================================
interface blowfish128_round_ctrl_if;
  logic         Start;    // block request
  logic         Decrypt;  // 1 = reverse subkey order
  logic [127:0] DataIn;   // {L, R}
  logic [4:0]   PAddr;    // subkey index
  logic [63:0]  PData;    // subkey, combinational from PAddr
  logic         FEn;      // F-function enable, low clears it
  logic [63:0]  FX;       // F-function operand
  logic [63:0]  FY;       // F-function result
  logic         FValid;   // F-function result valid
  logic         Busy;     // not IDLE
  logic         Done;     // one-cycle pulse, DataOut valid
  logic         Error;    // sticky timeout flag
  logic [127:0] DataOut;  // {L, R}

  modport slave (
    input  Start, Decrypt, DataIn, PData, FY, FValid,
    output PAddr, FEn, FX, Busy, Done, Error, DataOut
  );

  modport master (
    output Start, Decrypt, DataIn, PData, FY, FValid,
    input  PAddr, FEn, FX, Busy, Done, Error, DataOut
  );
endinterface
`default_nettype wire

// File: rtl/blowfish128_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : blowfish128_round_ctrl
// Description : Round sequencer for a 64-bit-half Blowfish-style Feistel
//               cipher. Walks ROUNDS rounds, fetching subkeys from an external
//               P-array and handshaking with an external F-function, then
//               applies the two output whitening subkeys.
// Ports       : Clk   - rising-edge clock
//               RstN  - asynchronous active-low reset
//               bus   - blowfish128_round_ctrl_if.slave (host, P, F signals)
// Parameters  : ROUNDS  - Feistel rounds (default 16)
//               TIMEOUT - max WAIT cycles per round before Error (default 15)
// Revision    : 1.0 - initial release
// ============================================================================
module blowfish128_round_ctrl #(
  parameter int ROUNDS  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                            Clk,
  input  logic                            RstN,
  blowfish128_round_ctrl_if.slave         bus
);

  localparam int         CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [4:0] ROUNDS_W = 5'(ROUNDS);
  localparam logic [4:0] LAST_KEY = 5'(ROUNDS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    WAIT = 3'd2,
    FIN1 = 3'd3,
    FIN2 = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t          state, state_next;
  logic [63:0]     left, right;
  logic [4:0]      rnd;
  logic [CW-1:0]   wait_cnt;
  logic            dec_mode;
  logic            done_q;
  logic            err_q;
  logic [127:0]    data_out_q;

  logic [4:0]      rnd_inc;
  logic [4:0]      key_round;
  logic [4:0]      key_fin1;
  logic [4:0]      key_fin2;

  assign rnd_inc   = rnd + 5'd1;
  // Decryption walks the P-array backwards: k(i) = ROUNDS+1-i.
  assign key_round = dec_mode ? (LAST_KEY - rnd) : rnd;
  assign key_fin1  = dec_mode ? 5'd1 : ROUNDS_W;
  assign key_fin2  = dec_mode ? 5'd0 : LAST_KEY;

  // --------------------------------------------------------------------------
  // State register and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state      <= IDLE;
      left       <= '0;
      right      <= '0;
      rnd        <= '0;
      wait_cnt   <= '0;
      dec_mode   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      state  <= state_next;
      // Registered so that Done lines up with the cycle DataOut is valid.
      done_q <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (bus.Start) begin
            left     <= bus.DataIn[127:64];
            right    <= bus.DataIn[63:0];
            dec_mode <= bus.Decrypt;
            rnd      <= '0;
            err_q    <= 1'b0;
          end
        end
        PREP: begin
          left     <= left ^ bus.PData;
          wait_cnt <= '0;
        end
        WAIT: begin
          if (bus.FValid) begin
            left  <= right ^ bus.FY;
            right <= left;
            rnd   <= rnd_inc;
          end else begin
            if (wait_cnt == CNT_LAST) begin
              err_q <= 1'b1;
            end
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        FIN1: begin
          // Undo the swap of the last round and apply k(ROUNDS).
          left  <= right;
          right <= left ^ bus.PData;
        end
        FIN2: begin
          left <= left ^ bus.PData;
        end
        DONE: begin
          data_out_q <= {left, right};
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    bus.PAddr  = 5'd0;
    bus.FEn    = 1'b0;
    bus.FX     = 64'd0;
    bus.Busy   = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (bus.Start) state_next = PREP;
      end
      PREP: begin
        bus.PAddr  = key_round;
        state_next = WAIT;
      end
      WAIT: begin
        bus.FEn = 1'b1;
        bus.FX  = left;
        if (bus.FValid) begin
          state_next = (rnd_inc < ROUNDS_W) ? PREP : FIN1;
        end else if (wait_cnt == CNT_LAST) begin
          state_next = IDLE;
        end
      end
      FIN1: begin
        bus.PAddr  = key_fin1;
        state_next = FIN2;
      end
      FIN2: begin
        bus.PAddr  = key_fin2;
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.Done    = done_q;
  assign bus.Error   = err_q;
  assign bus.DataOut = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_blowfish128_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_blowfish128_round_ctrl
// Description : Directed self-checking bench for blowfish128_round_ctrl with
//               a stub P-array and a stub F-function of selectable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blowfish128_round_ctrl;

  localparam int ROUNDS  = 16;
  localparam int TIMEOUT = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  blowfish128_round_ctrl_if bf_if ();

  blowfish128_round_ctrl #(
    .ROUNDS  (ROUNDS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .Clk  (clk),
    .RstN (rst_n),
    .bus  (bf_if)
  );

  always #5 clk = ~clk;

  // Stub configuration
  logic p_mode   = 1'b0;  // 0: P all zero; 1: P[i] = i*0x1111...
  logic f_mode   = 1'b0;  // 0: F = 0;      1: F = rotl8
  logic lat_mode = 1'b0;  // 0: N = 4;      1: N = 1..6 cycling per round
  logic f_never  = 1'b0;  // F never answers

  int n_checks = 0;
  int n_err    = 0;

  function automatic logic [63:0] p_of(input logic [4:0] a);
    return p_mode ? (64'h1111111111111111 * {59'd0, a}) : 64'd0;
  endfunction

  function automatic logic [63:0] f_of(input logic [63:0] x);
    return f_mode ? {x[55:0], x[63:56]} : 64'd0;
  endfunction

  function automatic int lat_of(input int r);
    return lat_mode ? (1 + (r % 6)) : 4;
  endfunction

  // Textbook Feistel form: L ^= P; R ^= F(L); swap; final unswap + whitening.
  function automatic logic [127:0] bf_model(input logic dec, input logic [127:0] din);
    logic [63:0] l, r, t;
    l = din[127:64];
    r = din[63:0];
    for (int i = 0; i < ROUNDS; i++) begin
      l = l ^ p_of(dec ? 5'(ROUNDS + 1 - i) : 5'(i));
      r = r ^ f_of(l);
      t = l; l = r; r = t;
    end
    t = l; l = r; r = t;
    r = r ^ p_of(dec ? 5'd1 : 5'(ROUNDS));
    l = l ^ p_of(dec ? 5'd0 : 5'(ROUNDS + 1));
    return {l, r};
  endfunction

  // Stub F-function: counts enabled cycles, answers on the N-th one.
  int f_cnt   = 0;
  int f_round = 0;

  always @(posedge clk) begin
    if (!bf_if.FEn) f_cnt <= 0;
    else            f_cnt <= f_cnt + 1;
    if (bf_if.Start && !bf_if.Busy) f_round <= 0;
    else if (bf_if.FValid)          f_round <= f_round + 1;
  end

  assign bf_if.FValid = bf_if.FEn && !f_never && (f_cnt == lat_of(f_round) - 1);
  assign bf_if.FY     = f_of(bf_if.FX);
  assign bf_if.PData  = p_of(bf_if.PAddr);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues Start (sampled at the next edge = edge 0) and follows the run until
  // Done. rep1/rep2: edge indices at which Start is pulsed again (0 = none).
  task automatic run_block(input logic dec, input logic [127:0] din,
                           input int rep1, input int rep2,
                           output logic [127:0] res, output int lat,
                           output int lowc, output int rises, output logic seen);
    logic prev_fen;
    bf_if.Decrypt = dec;
    bf_if.DataIn  = din;
    bf_if.Start   = 1'b1;
    @(posedge clk); #1;
    bf_if.Start = 1'b0;
    res = '0; lat = 0; lowc = 0; rises = 0; seen = 1'b0; prev_fen = 1'b0;
    for (int k = 0; k <= 400; k++) begin
      if (bf_if.Done) begin
        seen = 1'b1;
        lat  = k;
        res  = bf_if.DataOut;
        break;
      end
      if (bf_if.Busy && !bf_if.FEn) lowc++;
      if (bf_if.FEn && !prev_fen)   rises++;
      prev_fen = bf_if.FEn;
      bf_if.Start = ((k + 1) == rep1) || ((k + 1) == rep2);
      @(posedge clk); #1;
      bf_if.Start = 1'b0;
    end
  endtask

  function automatic int exp_latency();
    int s = 0;
    for (int r = 0; r < ROUNDS; r++) s += lat_of(r) + 1;
    return s + 3;
  endfunction

  initial begin
    logic [127:0] res, cipher, prev_out;
    int           lat, lowc, rises, exp_lat;
    logic         seen, done_any;
    localparam logic [127:0] VEC_A = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] EXP_A = 128'hFEDCBA9876543210_0123456789ABCDEF;
    localparam logic [127:0] VEC_B = 128'hDEADBEEFCAFEF00D_0011223344556677;

    bf_if.Start = 1'b0; bf_if.Decrypt = 1'b0; bf_if.DataIn = '0;

    // Reset state
    repeat (3) @(posedge clk); #1;
    check("rst_busy",    bf_if.Busy,    0);
    check("rst_done",    bf_if.Done,    0);
    check("rst_error",   bf_if.Error,   0);
    check("rst_dataout", bf_if.DataOut, 0);
    check("rst_fen",     bf_if.FEn,     0);
    check("rst_paddr",   bf_if.PAddr,   0);
    check("rst_fx",      bf_if.FX,      0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero P, zero F, N=4: only the swaps remain
    run_block(1'b0, VEC_A, 0, 0, res, lat, lowc, rises, seen);
    check("a_done_seen", seen, 1);
    check("a_result",    res,  EXP_A);
    check("a_latency",   lat,  83);
    check("a_fen_low",   lowc, 19);
    check("a_rounds",    rises, 16);
    @(posedge clk); #1;
    check("a_done_pulse", bf_if.Done, 0);
    check("a_idle",       bf_if.Busy, 0);
    check("a_hold",       bf_if.DataOut, EXP_A);

    // Start re-pulsed at edges 10 and 83 must be ignored
    run_block(1'b0, VEC_A, 10, 83, res, lat, lowc, rises, seen);
    check("rep_result",  res, EXP_A);
    check("rep_latency", lat, 83);
    @(posedge clk); #1;
    check("rep_no_restart", bf_if.Busy, 0);

    // P[i] = i*0x1111..., F = rotl8: encrypt then decrypt
    p_mode = 1'b1; f_mode = 1'b1;
    run_block(1'b0, VEC_B, 0, 0, cipher, lat, lowc, rises, seen);
    check("b_enc_result",  cipher, bf_model(1'b0, VEC_B));
    check("b_enc_latency", lat, 83);
    @(posedge clk); #1;
    run_block(1'b1, cipher, 0, 0, res, lat, lowc, rises, seen);
    check("b_dec_roundtrip", res, VEC_B);
    check("b_dec_latency",   lat, 83);
    @(posedge clk); #1;

    // Variable F latency N = 1..6
    lat_mode = 1'b1;
    exp_lat  = exp_latency();
    run_block(1'b0, VEC_A, 0, 0, res, lat, lowc, rises, seen);
    check("v_result",  res,   bf_model(1'b0, VEC_A));
    check("v_latency", lat,   exp_lat);
    check("v_fen_low", lowc,  19);
    check("v_rounds",  rises, 16);
    @(posedge clk); #1;
    lat_mode = 1'b0;
    prev_out = bf_if.DataOut;

    // F never answers: timeout after 1 PREP + 15 WAIT cycles
    f_never = 1'b1;
    bf_if.Decrypt = 1'b0; bf_if.DataIn = VEC_B; bf_if.Start = 1'b1;
    @(posedge clk); #1;
    bf_if.Start = 1'b0;
    repeat (15) @(posedge clk); #1;
    check("to_pre_error", bf_if.Error, 0);
    check("to_pre_busy",  bf_if.Busy,  1);
    @(posedge clk); #1;
    check("to_error", bf_if.Error, 1);
    check("to_busy",  bf_if.Busy,  0);
    done_any = 1'b0;
    for (int k = 0; k < 6; k++) begin
      done_any = done_any | bf_if.Done;
      @(posedge clk); #1;
    end
    check("to_no_done",  done_any, 0);
    check("to_sticky",   bf_if.Error, 1);
    check("to_dataout",  bf_if.DataOut, prev_out);
    f_never = 1'b0;

    // Reset during round 7 WAIT, then an immediate new Start
    bf_if.Decrypt = 1'b0; bf_if.DataIn = VEC_B; bf_if.Start = 1'b1;
    @(posedge clk); #1;
    bf_if.Start = 1'b0;
    check("rs_error_cleared", bf_if.Error, 0);
    begin
      int   r7 = 0;
      logic pf = 1'b0;
      for (int k = 0; k < 200 && r7 < 7; k++) begin
        @(posedge clk); #1;
        if (bf_if.FEn && !pf) r7++;
        pf = bf_if.FEn;
      end
      check("rs_reached_r7", r7, 7);
    end
    @(posedge clk); #3;
    check("rs_pre_busy", bf_if.Busy, 1);
    rst_n = 1'b0;
    #1;
    check("rs_busy",    bf_if.Busy,    0);
    check("rs_fen",     bf_if.FEn,     0);
    check("rs_fx",      bf_if.FX,      0);
    check("rs_paddr",   bf_if.PAddr,   0);
    check("rs_dataout", bf_if.DataOut, 0);
    check("rs_error",   bf_if.Error,   0);
    check("rs_done",    bf_if.Done,    0);
    @(negedge clk);
    rst_n = 1'b1;
    run_block(1'b0, VEC_B, 0, 0, res, lat, lowc, rises, seen);
    check("rs_new_result",  res, bf_model(1'b0, VEC_B));
    check("rs_new_latency", lat, 83);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
